// File: rtl/display_source_seq.sv
// Registered display-source selector: shows one of CHANNELS values, chosen manually
// or by timed rotation through the enabled channels, with a hold that freezes everything.
module display_source_seq #(
    parameter int WIDTH    = 14,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS),
    parameter int DWELL    = 100_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] ch_data,
    input  logic [CHANNELS-1:0]       ch_en,
    input  logic [SEL_W-1:0]          sel_manual,
    input  logic                      auto_en,
    input  logic                      hold,
    output logic [WIDTH-1:0]          out,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      sel_changed
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] SEL_MAX  = SEL_W'(CHANNELS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             chg_q, chg_d;
    logic [SEL_W-1:0] nextAuto;
    logic [SEL_W-1:0] nextSel;
    logic             found;

    // Circular search for the first enabled channel after the current one; the
    // current channel itself is never a candidate, so a lone or empty mask stays put.
    always_comb begin
        nextAuto = sel_q;
        found    = 1'b0;
        for (int i = 1; i < CHANNELS; i++) begin
            if (!found && ch_en[(int'(sel_q) + i) % CHANNELS]) begin
                nextAuto = SEL_W'((int'(sel_q) + i) % CHANNELS);
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        out_d   = out_q;
        chg_d   = 1'b0;
        nextSel = sel_q;
        if (!hold) begin
            if (auto_en) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    nextSel = nextAuto;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    nextSel = sel_q;
                end
            end else begin
                cnt_d   = '0;
                nextSel = (sel_manual > SEL_MAX) ? SEL_MAX : sel_manual;
            end
            sel_d = nextSel;
            out_d = ch_data[int'(nextSel)*WIDTH +: WIDTH];
            chg_d = (nextSel != sel_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            sel_q <= '0;
            out_q <= '0;
            chg_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
            out_q <= out_d;
            chg_q <= chg_d;
        end
    end

    assign out         = out_q;
    assign cur_sel     = sel_q;
    assign sel_changed = chg_q;

endmodule

// File: tb/tb_display_source_seq.sv
// Directed self-checking bench for display_source_seq (DWELL=4, channel k = 0x100+k),
// plus a three-channel instance for the manual clamp.
module tb_display_source_seq;

    localparam int W = 14;

    logic            clk;
    logic            reset;
    logic [4*W-1:0]  chData;
    logic [3:0]      chEn;
    logic [1:0]      selManual;
    logic            autoEn;
    logic            hold;
    logic [W-1:0]    dOut;
    logic [1:0]      curSel;
    logic            selChanged;

    logic [3*W-1:0]  chData3;
    logic [2:0]      chEn3;
    logic [1:0]      selManual3;
    logic [W-1:0]    dOut3;
    logic [1:0]      curSel3;
    logic            selChanged3;

    int errors = 0;
    int checks = 0;

    display_source_seq #(.WIDTH(W), .CHANNELS(4), .DWELL(4)) u_dut (
        .clk(clk), .reset(reset), .ch_data(chData), .ch_en(chEn),
        .sel_manual(selManual), .auto_en(autoEn), .hold(hold),
        .out(dOut), .cur_sel(curSel), .sel_changed(selChanged)
    );

    display_source_seq #(.WIDTH(W), .CHANNELS(3), .DWELL(4)) u_dut3 (
        .clk(clk), .reset(reset), .ch_data(chData3), .ch_en(chEn3),
        .sel_manual(selManual3), .auto_en(1'b0), .hold(1'b0),
        .out(dOut3), .cur_sel(curSel3), .sel_changed(selChanged3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are changed and outputs sampled 1 time unit after each rising edge
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkMain(input string tag, input int expSel, input logic expChg);
        checkOutput({tag, ".cur_sel"}, 32'(curSel), 32'(expSel));
        checkOutput({tag, ".out"}, 32'(dOut), 32'h100 + 32'(expSel));
        checkOutput({tag, ".sel_changed"}, 32'(selChanged), 32'(expChg));
    endtask

    task automatic setDefaultData();
        for (int k = 0; k < 4; k++) chData[k*W +: W] = W'(14'h100 + k);
    endtask

    initial begin
        int expSel;
        reset      = 1'b1;
        autoEn     = 1'b0;
        hold       = 1'b0;
        selManual  = 2'd0;
        chEn       = 4'b0000;
        setDefaultData();
        for (int k = 0; k < 3; k++) chData3[k*W +: W] = W'(14'h200 + k);
        chEn3      = 3'b000;
        selManual3 = 2'd3;

        // Reset and manual selection
        applyStimulus(2);
        checkOutput("reset.out", 32'(dOut), 32'h0);
        checkOutput("reset.cur_sel", 32'(curSel), 32'h0);
        checkOutput("reset.sel_changed", 32'(selChanged), 32'h0);
        checkOutput("reset3.cur_sel", 32'(curSel3), 32'h0);
        reset     = 1'b0;
        selManual = 2'd2;
        applyStimulus(1);
        checkMain("manual2", 2, 1'b1);
        checkOutput("clamp3.cur_sel", 32'(curSel3), 32'h2);
        checkOutput("clamp3.out", 32'(dOut3), 32'h202);
        applyStimulus(1);
        checkMain("manual2.settled", 2, 1'b0);
        chData[2*W +: W] = 14'h3FFF;
        applyStimulus(1);
        checkOutput("manual.live_data", 32'(dOut), 32'h3FFF);
        setDefaultData();

        // Auto rotation with wrap, starting from channel 3
        selManual = 2'd3;
        applyStimulus(1);
        checkMain("start3", 3, 1'b1);
        autoEn = 1'b1;
        chEn   = 4'b1111;
        for (int e = 1; e <= 20; e++) begin
            applyStimulus(1);
            checkMain("rotate", (3 + e / 4) % 4, (e % 4) == 0);
        end

        // Skip mask 1010 from channel 1
        autoEn    = 1'b0;
        selManual = 2'd1;
        applyStimulus(1);
        checkMain("start1", 1, 1'b1);
        autoEn = 1'b1;
        chEn   = 4'b1010;
        for (int e = 1; e <= 12; e++) begin
            applyStimulus(1);
            expSel = ((e / 4) % 2 == 1) ? 3 : 1;
            checkMain("skip1010", expSel, (e % 4) == 0);
        end

        // Lone enabled channel equal to current, then empty mask
        autoEn = 1'b0;
        applyStimulus(1);
        checkMain("back1", 1, 1'b1);
        autoEn = 1'b1;
        chEn   = 4'b0010;
        for (int e = 1; e <= 8; e++) begin
            applyStimulus(1);
            checkMain("lone0010", 1, 1'b0);
        end
        chEn = 4'b0000;
        for (int e = 1; e <= 8; e++) begin
            applyStimulus(1);
            checkMain("empty_mask", 1, 1'b0);
        end

        // Hold two cycles into a dwell while the sources change
        chEn = 4'b1111;
        applyStimulus(2);
        checkMain("prehold", 1, 1'b0);
        hold = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            for (int k = 0; k < 4; k++) chData[k*W +: W] = W'(14'h2000 + 16 * e + k);
            applyStimulus(1);
            checkMain("hold", 1, 1'b0);
        end
        hold = 1'b0;
        setDefaultData();
        applyStimulus(1);
        checkMain("release.e1", 1, 1'b0);
        applyStimulus(1);
        checkMain("release.e2", 2, 1'b1);

        // Auto to manual at counter 2, then back to auto
        applyStimulus(2);
        checkMain("auto.cnt2", 2, 1'b0);
        autoEn    = 1'b0;
        selManual = 2'd0;
        applyStimulus(1);
        checkMain("to_manual", 0, 1'b1);
        autoEn = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            applyStimulus(1);
            checkMain("to_auto", (e == 4) ? 1 : 0, e == 4);
        end

        // Reset while held in auto with counter at 3
        applyStimulus(3);
        checkMain("precnt3", 1, 1'b0);
        hold  = 1'b1;
        reset = 1'b1;
        applyStimulus(1);
        checkOutput("midreset.out", 32'(dOut), 32'h0);
        checkOutput("midreset.cur_sel", 32'(curSel), 32'h0);
        checkOutput("midreset.sel_changed", 32'(selChanged), 32'h0);
        reset = 1'b0;
        hold  = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            applyStimulus(1);
            checkMain("postreset", (e == 4) ? 1 : 0, e == 4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_source_seq.md
# display_source_seq

Parametrised, registered display-source selector for the seven-segment display path. Picks one of `CHANNELS` `WIDTH`-bit values (score, switch inputs, last turn, random number, …) for the display driver. Selection is either manual from a select input or automatic: the block rotates through the enabled channels after a programmable dwell time. A hold input freezes the shown value and selection, so a result can stay on screen.

## Interface
- `WIDTH`, 14, bits per channel value
- `CHANNELS`, 4, number of sources; must be ≥2
- `SEL_W`, `$clog2(CHANNELS)`, select width
- `DWELL`, 100_000_000, cycles each channel is shown in auto mode; must be ≥1

- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `ch_data`  in  `CHANNELS*WIDTH`  flattened sources; channel k = `ch_data[k*WIDTH +: WIDTH]`
- `ch_en`  in  `CHANNELS`  auto-mode enable mask; bit k enables channel k
- `sel_manual`  in  `SEL_W`  manual channel select
- `auto_en`  in  1  1 = auto rotate, 0 = manual
- `hold`  in  1  freeze `out`, `cur_sel` and dwell counter
- `out`  out  `WIDTH`  registered displayed value
- `cur_sel`  out  `SEL_W`  registered current channel
- `sel_changed`  out  1  one-cycle pulse when `cur_sel` changed on that edge

## Operation
- **Priority each edge:** `reset` > `hold` > mode logic.
- **Reset values:**
  - `out` = 0
  - `cur_sel` = 0
  - dwell counter = 0
  - `sel_changed` = 0
- **Hold:** all registers keep their value and `sel_changed` = 0. Changes on `ch_data` are ignored while held.
- **Datapath:** each edge that is not reset and not hold computes `next_sel` and loads:
  - `cur_sel` <= `next_sel`
  - `out` <= channel `next_sel` of the current `ch_data`
  - `sel_changed` <= (`next_sel` != `cur_sel`)
- **Manual (`auto_en`=0):**
  - `next_sel` = `sel_manual`.
  - A value ≥ `CHANNELS` clamps to `CHANNELS-1`.
  - The dwell counter is forced to 0.
  - `ch_en` is ignored.
- **Auto (`auto_en`=1):**
  - The counter increments each non-hold edge.
  - When counter = `DWELL-1`, the counter goes to 0 and `next_sel` = the first enabled channel after `cur_sel`, searching circularly (`CHANNELS-1` wraps to 0).
  - Otherwise `next_sel` = `cur_sel`.
- **Skip rules:**
  - If the only enabled channel is `cur_sel`, or `ch_en` = 0, `next_sel` = `cur_sel` and no pulse occurs.
  - A disabled current channel keeps displaying until its dwell expires.
- **Mode switches:**
  - Manual→auto: rotation starts from the current `cur_sel` with counter = 0. The first advance comes `DWELL` edges later.
  - Auto→manual: `sel_manual` takes effect on the same edge and the counter clears.
- **Reset mid-dwell:** the counter returns to 0 and `cur_sel` returns to 0, regardless of mode or hold.

## Timing
- Latency is 1 cycle from `sel_manual`, `ch_data` or `ch_en` sampled at edge N to `out`/`cur_sel` valid after edge N.
- `out` tracks live `ch_data` of the selected channel with that 1-cycle latency, except under hold.
- In auto mode with a constant mask, each channel is shown for exactly `DWELL` cycles.
- `DWELL`=1 advances on every edge.
- `sel_changed` is high for exactly the one cycle after the edge on which `cur_sel` changed.
- Deasserting `hold` resumes from the frozen counter value. The remaining dwell is preserved.
- Counter width is `$clog2(DWELL)`, minimum 1. No overflow is possible because it wraps at `DWELL-1`.

## Test plan
- **Reset/manual:** bench uses DWELL=4 and channel k = 0x100+k.
  - Hold `reset` for 2 cycles, then `auto_en`=0, `sel_manual`=2.
  - After the first edge: `out`=0x102, `cur_sel`=2, `sel_changed`=1. It is 0 on the next cycle.
  - Change channel 2 to 0x3FFF; `out`=0x3FFF one cycle later.
- **Auto rotation/wrap:** `auto_en`=1, `ch_en`=4'b1111, start at `cur_sel`=3.
  - `cur_sel` = 3 for 4 cycles, then 0, 1, 2, 3, 0, each for 4 cycles.
  - `sel_changed` pulses once per change.
- **Skip mask:** `ch_en`=4'b1010, start at `cur_sel`=1 → sequence 1,3,1,3.
  - `ch_en`=4'b0010 with `cur_sel`=1 → stays at 1 with no pulses.
  - `ch_en`=0 → no change.
- **Hold:** assert `hold` 2 cycles into a dwell for 10 cycles while changing all `ch_data`.
  - `out` and `cur_sel` stay constant.
  - After release, the advance occurs 2 edges later.
- **Mode switching:**
  - Auto at counter=2, switch to manual with `sel_manual`=0 → `cur_sel`=0 next edge.
  - Return to auto → first advance to 1 occurs 4 edges later.
  - With CHANNELS=3 and manual `sel_manual`=3 → clamps to `cur_sel`=2.
- **Reset mid-operation:** assert `reset` while in auto with hold=1 and counter=3.
  - Next edge: `out`=0, `cur_sel`=0, `sel_changed`=0.
  - After release in auto, the first advance comes 4 edges later.
